// File: rtl/branch_pc_unit.sv
// Branch resolution and next-PC selection with registered NZCV flags and a
// circular return-address stack that predicts BR X30 targets.
module branch_pc_unit #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        take_branch,
    input  logic                        reg_branch,
    input  logic [1:0]                  br_kind,
    input  logic [3:0]                  cond,
    input  logic                        is_link,
    input  logic                        is_ret,
    input  logic [ADDR_W-1:0]           se_imm,
    input  logic [ADDR_W-1:0]           reg_data,
    input  logic                        alu_zero,
    input  logic [3:0]                  alu_flags,
    input  logic                        flag_write,
    output logic [ADDR_W-1:0]           pc,
    output logic [ADDR_W-1:0]           link_addr,
    output logic                        branch_taken,
    output logic [3:0]                  flags_q,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_underflow
);

    localparam int unsigned       PTR_W      = $clog2(RAS_DEPTH);
    localparam int unsigned       CNT_W      = PTR_W + 1;
    localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(4);

    typedef enum logic [1:0] {
        BR_UNCOND = 2'b00,
        BR_CBZ    = 2'b01,
        BR_COND   = 2'b10,
        BR_RSVD   = 2'b11
    } br_kind_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        flags_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;     // next free slot; top is ras_ptr_q-1
    logic [CNT_W-1:0]  ras_count_q, ras_count_d;

    br_kind_e          kind;
    logic              ras_empty;
    logic              ras_full;
    logic              push;
    logic              pop_req;
    logic              pop;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] rel_target;
    logic [ADDR_W-1:0] reg_target;

    // Odd condition codes invert the predicate of the even code below them;
    // 111x means "always" regardless of the low bit.
    function automatic logic cond_holds(input logic [3:0] code, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        {n, z, c, v} = nzcv;
        case (code[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (code[3:1] == 3'd7) ? 1'b1 : (base ^ code[0]);
    endfunction

    always_comb begin : resolve
        kind         = br_kind_e'(br_kind);
        branch_taken = 1'b0;
        if (take_branch) begin
            case (kind)
                BR_UNCOND: branch_taken = 1'b1;
                BR_CBZ:    branch_taken = alu_zero;
                BR_COND:   branch_taken = cond_holds(cond, flags_q);
                default:   branch_taken = 1'b0;
            endcase
        end
    end

    assign link_addr  = pc_q + INSN_BYTES;
    assign rel_target = pc_q + (se_imm << 2);

    assign ras_empty  = (ras_count_q == '0);
    assign ras_full   = (ras_count_q == CNT_W'(RAS_DEPTH));
    assign ras_top    = ras_q[ras_ptr_q - PTR_W'(1)];
    assign reg_target = (is_ret && !ras_empty) ? ras_top : reg_data;

    // A link on the same instruction wins over a return: push only.
    assign push          = branch_taken & is_link & ~stall;
    assign pop_req       = branch_taken & reg_branch & is_ret & ~is_link & ~stall;
    assign pop           = pop_req & ~ras_empty;
    assign ras_underflow = pop_req & ras_empty;

    always_comb begin : next_state
        // NOTE: every variable gets its hold value first, so no path can leave
        // one unassigned and infer a latch.
        pc_d        = pc_q;
        flags_d     = flags_q;
        ras_d       = ras_q;
        ras_ptr_d   = ras_ptr_q;
        ras_count_d = ras_count_q;

        if (!stall) begin
            if (branch_taken && reg_branch) begin
                pc_d = reg_target;
            end else if (branch_taken) begin
                pc_d = rel_target;
            end else begin
                pc_d = link_addr;
            end

            if (flag_write) begin
                flags_d = alu_flags;
            end

            // When full, the write slot is the oldest entry, so the push
            // overwrites it and the count saturates.
            if (push) begin
                ras_d[ras_ptr_q] = link_addr;
                ras_ptr_d        = ras_ptr_q + PTR_W'(1);
                if (!ras_full) begin
                    ras_count_d = ras_count_q + CNT_W'(1);
                end
            end else if (pop) begin
                ras_ptr_d   = ras_ptr_q - PTR_W'(1);
                ras_count_d = ras_count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            pc_q        <= RESET_PC;
            flags_q     <= '0;
            ras_ptr_q   <= '0;
            ras_count_q <= '0;
            // NOTE: the stack entries are cleared on reset as well, so a
            // freshly reset unit never exposes stale return addresses.
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_count_q <= ras_count_d;
            ras_q       <= ras_d;
        end
    end

    assign pc        = pc_q;
    assign ras_count = ras_count_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: condition-code table, directed
// multi-cycle sequences, then random stimulus against a queue-based model.
module tb_branch_pc_unit;

    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [63:0] RESET_PC  = 64'h0;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        take_branch;
    logic        reg_branch;
    logic [1:0]  br_kind;
    logic [3:0]  cond;
    logic        is_link;
    logic        is_ret;
    logic [63:0] se_imm;
    logic [63:0] reg_data;
    logic        alu_zero;
    logic [3:0]  alu_flags;
    logic        flag_write;
    logic [63:0] pc;
    logic [63:0] link_addr;
    logic        branch_taken;
    logic [3:0]  flags_q;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    branch_pc_unit #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .take_branch  (take_branch),
        .reg_branch   (reg_branch),
        .br_kind      (br_kind),
        .cond         (cond),
        .is_link      (is_link),
        .is_ret       (is_ret),
        .se_imm       (se_imm),
        .reg_data     (reg_data),
        .alu_zero     (alu_zero),
        .alu_flags    (alu_flags),
        .flag_write   (flag_write),
        .pc           (pc),
        .link_addr    (link_addr),
        .branch_taken (branch_taken),
        .flags_q      (flags_q),
        .ras_count    (ras_count),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the stack is a queue, newest entry at the back.
    logic [63:0] m_pc;
    logic [3:0]  m_flags;
    logic [63:0] m_ras[$];

    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] code;
        logic       exp;
    } cond_vec_t;

    cond_vec_t   cond_tbl[20];
    logic [63:0] lifo_exp[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_cond(input logic [3:0] code, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !(c && !z);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    task automatic idle();
        reset = 0; stall = 0; take_branch = 0; reg_branch = 0; br_kind = 2'b00;
        cond = 4'h0; is_link = 0; is_ret = 0; se_imm = '0; reg_data = '0;
        alu_zero = 0; alu_flags = 4'h0; flag_write = 0;
    endtask

    // Called at a falling edge with inputs set: compare against the model,
    // advance the model across the next rising edge, return at the falling edge.
    task automatic tick();
        bit          taken, uf;
        logic [63:0] nxt;
        #1;
        taken = take_branch && ((br_kind == 2'b00) ||
                                (br_kind == 2'b01 && alu_zero) ||
                                (br_kind == 2'b10 && ref_cond(cond, m_flags)));
        uf = taken && reg_branch && is_ret && !is_link && !stall && (m_ras.size() == 0);
        check("pc", pc, m_pc);
        check("link_addr", link_addr, m_pc + 64'd4);
        check("branch_taken", branch_taken, taken);
        check("flags_q", flags_q, m_flags);
        check("ras_count", ras_count, m_ras.size());
        check("ras_underflow", ras_underflow, uf);
        if (reset) begin
            m_pc = RESET_PC;
            m_flags = 4'h0;
            m_ras.delete();
        end else if (!stall) begin
            if (taken && reg_branch)
                nxt = (is_ret && m_ras.size() > 0) ? m_ras[$] : reg_data;
            else if (taken)
                nxt = m_pc + se_imm * 64'd4;
            else
                nxt = m_pc + 64'd4;
            if (taken && is_link) begin
                m_ras.push_back(m_pc + 64'd4);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end else if (taken && reg_branch && is_ret && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
            if (flag_write) m_flags = alu_flags;
            m_pc = nxt;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic bl(input logic [63:0] imm);
        idle();
        take_branch = 1; is_link = 1; se_imm = imm;
        tick();
    endtask

    task automatic ret(input logic [63:0] rd);
        idle();
        take_branch = 1; reg_branch = 1; is_ret = 1; reg_data = rd;
    endtask

    initial begin
        cond_tbl[0]  = '{4'b0100, 4'h0, 1'b1};
        cond_tbl[1]  = '{4'b0000, 4'h0, 1'b0};
        cond_tbl[2]  = '{4'b0100, 4'h1, 1'b0};
        cond_tbl[3]  = '{4'b0010, 4'h2, 1'b1};
        cond_tbl[4]  = '{4'b0010, 4'h3, 1'b0};
        cond_tbl[5]  = '{4'b1000, 4'h4, 1'b1};
        cond_tbl[6]  = '{4'b1000, 4'h5, 1'b0};
        cond_tbl[7]  = '{4'b0001, 4'h6, 1'b1};
        cond_tbl[8]  = '{4'b0000, 4'h7, 1'b1};
        cond_tbl[9]  = '{4'b0010, 4'h8, 1'b1};
        cond_tbl[10] = '{4'b0110, 4'h8, 1'b0};
        cond_tbl[11] = '{4'b0110, 4'h9, 1'b1};
        cond_tbl[12] = '{4'b1001, 4'hA, 1'b1};
        cond_tbl[13] = '{4'b1000, 4'hB, 1'b1};
        cond_tbl[14] = '{4'b0000, 4'hC, 1'b1};
        cond_tbl[15] = '{4'b0100, 4'hC, 1'b0};
        cond_tbl[16] = '{4'b0100, 4'hD, 1'b1};
        cond_tbl[17] = '{4'b1000, 4'hD, 1'b1};
        cond_tbl[18] = '{4'b0000, 4'hE, 1'b1};
        cond_tbl[19] = '{4'b0000, 4'hF, 1'b1};
        lifo_exp = '{64'h44, 64'h34, 64'h24, 64'h14};

        // First reset: DUT state is unknown until this edge, so no model check.
        idle();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        m_pc = RESET_PC; m_flags = 4'h0; m_ras.delete();
        #1;
        check("reset_pc", pc, RESET_PC);
        check("reset_flags", flags_q, 4'h0);
        check("reset_ras_count", ras_count, 3'd0);

        // Sequential fetch
        tick(); check("seq_pc_4", pc, 64'h4);
        tick(); check("seq_pc_8", pc, 64'h8);
        tick(); check("seq_pc_c", pc, 64'hC);
        tick(); check("seq_pc_10", pc, 64'h10);

        // Relative branch backwards, then a not-taken CBZ
        take_branch = 1; se_imm = -64'sd2;
        tick(); check("b_neg_pc", pc, 64'h8);
        idle(); tick(); tick();
        take_branch = 1; br_kind = 2'b01; alu_zero = 0; se_imm = -64'sd2;
        tick(); check("cbz_nt_pc", pc, 64'h14);

        // Reserved kind and non-branch never take
        idle(); take_branch = 1; br_kind = 2'b11;
        #1 check("rsvd_not_taken", branch_taken, 1'b0);
        tick();
        idle(); take_branch = 0; br_kind = 2'b00;
        #1 check("no_branch_not_taken", branch_taken, 1'b0);
        tick();

        // Condition-code table
        foreach (cond_tbl[i]) begin
            idle(); flag_write = 1; alu_flags = cond_tbl[i].nzcv;
            tick();
            idle(); take_branch = 1; br_kind = 2'b10; cond = cond_tbl[i].code;
            #1 check($sformatf("cond_tbl_%0d", i), branch_taken, cond_tbl[i].exp);
            tick();
        end

        // Flag timing: B.cond sees only flags registered before this cycle
        idle(); flag_write = 1; alu_flags = 4'b1000;
        tick();
        idle(); take_branch = 1; br_kind = 2'b10; cond = 4'hB;
        #1 check("blt_taken", branch_taken, 1'b1);
        tick();
        cond = 4'hA;
        #1 check("bge_not_taken", branch_taken, 1'b0);
        tick();
        cond = 4'hB; flag_write = 1; alu_flags = 4'b0000;
        #1 check("blt_old_flags", branch_taken, 1'b1);
        tick();
        idle(); take_branch = 1; br_kind = 2'b10; cond = 4'hB;
        #1 check("blt_new_flags", branch_taken, 1'b0);
        check("flags_loaded", flags_q, 4'h0);
        tick();

        // BL then return through the stack
        do_reset();
        idle(); take_branch = 1; se_imm = 64'd8;
        tick(); check("at_0x20", pc, 64'h20);
        bl(64'd4);
        check("bl_pc", pc, 64'h30);
        check("bl_count", ras_count, 3'd1);
        ret(64'h999);
        tick();
        check("ret_pc", pc, 64'h24);
        check("ret_count", ras_count, 3'd0);

        // Overflow by one, then drain past empty
        do_reset();
        for (int i = 0; i < RAS_DEPTH + 1; i++) bl(64'd4);
        check("ovf_pc", pc, 64'h50);
        check("ovf_count", ras_count, 3'(RAS_DEPTH));
        for (int i = 0; i < RAS_DEPTH; i++) begin
            ret(64'h999);
            #1 check($sformatf("lifo_uf_%0d", i), ras_underflow, 1'b0);
            tick();
            check($sformatf("lifo_pc_%0d", i), pc, lifo_exp[i]);
        end
        ret(64'h999);
        #1 check("underflow_flag", ras_underflow, 1'b1);
        tick();
        check("underflow_pc", pc, 64'h999);
        check("underflow_count", ras_count, 3'd0);

        // PC wraps modulo 2^64
        idle(); take_branch = 1; reg_branch = 1; reg_data = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        idle();
        #1 check("wrap_link", link_addr, 64'h0);
        tick(); check("wrap_pc", pc, 64'h0);

        // Stall freezes state; reset during stall still wins
        do_reset();
        idle(); take_branch = 1; is_link = 1; se_imm = 64'd4; flag_write = 1; alu_flags = 4'b0110;
        tick();
        idle(); stall = 1; take_branch = 1; is_link = 1; se_imm = 64'd100;
        flag_write = 1; alu_flags = 4'b1111;
        #1 check("stall_taken", branch_taken, 1'b1);
        tick();
        check("stall_pc", pc, 64'h10);
        check("stall_flags", flags_q, 4'b0110);
        check("stall_count", ras_count, 3'd1);
        reset = 1;
        tick();
        check("stall_reset_pc", pc, RESET_PC);
        check("stall_reset_flags", flags_q, 4'h0);
        check("stall_reset_count", ras_count, 3'd0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(63) == 0);
            stall       = ($urandom_range(3) == 0);
            take_branch = $urandom_range(1);
            reg_branch  = ($urandom_range(2) == 0);
            br_kind     = 2'($urandom_range(3));
            cond        = 4'($urandom_range(15));
            is_link     = ($urandom_range(3) == 0);
            is_ret      = ($urandom_range(2) == 0);
            se_imm      = ($urandom_range(1) == 0) ? {$urandom, $urandom}
                                                   : 64'($signed(8'($urandom)));
            reg_data    = {$urandom, $urandom};
            alu_zero    = $urandom_range(1);
            alu_flags   = 4'($urandom_range(15));
            flag_write  = $urandom_range(1);
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
